// File: rtl/clk_gen_pkg.sv
// rtl/clk_gen_pkg.sv - shared types and sizing helpers for the clock-enable generator
package clk_gen_pkg;

  typedef enum logic [1:0] {WAIT_LOCK, STABLE, RUN} lock_state_t;

  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_CYCLES = 1024;
  localparam int LOCK_CNT_W      = $clog2(DEF_LOCK_CYCLES);

  typedef logic [DEF_DIV_W-1:0] div_t;

  // Lock counter must reach cycles-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/clk_en_ch.sv
// rtl/clk_en_ch.sv - one divide-by-D clock-enable channel with glitch-free divisor update
module clk_en_ch #(
  parameter int DIV_W   = 8,
  parameter int DIV_RST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             en,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  output logic             ce
);

  localparam logic [DIV_W-1:0] RST_D = DIV_W'(DIV_RST);

  logic [DIV_W-1:0] pending_d;
  logic [DIV_W-1:0] active_d;
  logic [DIV_W-1:0] cnt;

  // Divisor 0 behaves as 1, so its reload value is also 0.
  function automatic logic [DIV_W-1:0] reload(input logic [DIV_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_d <= RST_D;
      active_d  <= RST_D;
      cnt       <= '0;
      ce        <= 1'b0;
    end else begin
      if (load) begin
        pending_d <= div;
      end
      if (run && en) begin
        // The active divisor only changes at a terminal count, so a
        // period in progress is never shortened or stretched.
        if (cnt == '0) begin
          ce       <= 1'b1;
          active_d <= pending_d;
          cnt      <= reload(pending_d);
        end else begin
          ce  <= 1'b0;
          cnt <= cnt - 1'b1;
        end
      end else begin
        ce       <= 1'b0;
        active_d <= pending_d;
        cnt      <= reload(pending_d);
      end
    end
  end

  logic unused_active;
  assign unused_active = ^active_d;

endmodule

// File: rtl/clk_en_gen.sv
// rtl/clk_en_gen.sv - MMCM lock supervisor driving NUM_CH phase-aligned clock-enable channels
module clk_en_gen
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int LOCK_CYCLES = 1024,
  parameter int DIV_RST     = 1
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_locked,
  input  logic [NUM_CH*DIV_W-1:0] i_div,
  input  logic                    i_div_load,
  input  logic [NUM_CH-1:0]       i_ch_en,
  input  logic                    i_clr_status,
  output logic [NUM_CH-1:0]       o_ce,
  output logic                    o_ready,
  output logic                    o_rst_out,
  output logic                    o_lost_lock
);

  localparam int               CNT_W     = cnt_width(LOCK_CYCLES);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic             lock_meta;
  logic             lock_sync;
  lock_state_t      state;
  logic [CNT_W-1:0] lock_cnt;
  logic             ch_run;

  // Channels stop on the very edge the FSM leaves RUN, so a lock drop
  // never lets one more strobe through.
  assign ch_run = (state == RUN) && lock_sync;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      lock_meta   <= 1'b0;
      lock_sync   <= 1'b0;
      state       <= WAIT_LOCK;
      lock_cnt    <= '0;
      o_ready     <= 1'b0;
      o_rst_out   <= 1'b1;
      o_lost_lock <= 1'b0;
    end else begin
      lock_meta <= i_locked;
      lock_sync <= lock_meta;
      if (i_clr_status) begin
        o_lost_lock <= 1'b0;
      end
      case (state)
        WAIT_LOCK: begin
          if (lock_sync) begin
            state    <= STABLE;
            lock_cnt <= '0;
          end
        end
        STABLE: begin
          if (!lock_sync) begin
            state <= WAIT_LOCK;
          end else if (lock_cnt == LOCK_LAST) begin
            state     <= RUN;
            o_ready   <= 1'b1;
            o_rst_out <= 1'b0;
          end else begin
            lock_cnt <= lock_cnt + 1'b1;
          end
        end
        RUN: begin
          // Written after the clear so a simultaneous clear loses.
          if (!lock_sync) begin
            state       <= WAIT_LOCK;
            o_ready     <= 1'b0;
            o_rst_out   <= 1'b1;
            o_lost_lock <= 1'b1;
          end
        end
        default: begin
          state     <= WAIT_LOCK;
          o_ready   <= 1'b0;
          o_rst_out <= 1'b1;
        end
      endcase
    end
  end

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    clk_en_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk  (i_clk),
      .rst  (i_reset),
      .run  (ch_run),
      .en   (i_ch_en[n]),
      .load (i_div_load),
      .div  (i_div[n*DIV_W +: DIV_W]),
      .ce   (o_ce[n])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
// tb/tb_clk_en_gen.sv - scoreboard bench for clk_en_gen
module tb_clk_en_gen;

  localparam int NUM_CH      = 4;
  localparam int DIV_W       = 8;
  localparam int LOCK_CYCLES = 8;
  localparam int DIV_RST     = 1;
  // Posedges counted including the one that first samples i_locked=1.
  localparam int EXP_EDGES   = LOCK_CYCLES + 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    locked;
  logic [NUM_CH*DIV_W-1:0] div;
  logic                    div_load;
  logic [NUM_CH-1:0]       ch_en;
  logic                    clr;
  logic [NUM_CH-1:0]       ce;
  logic                    ready;
  logic                    rst_out;
  logic                    lost;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [NUM_CH-1:0] ce;
    logic [NUM_CH-1:0] mask;
  } sb_t;
  sb_t sb_q[$];

  always #5 clk = ~clk;

  clk_en_gen #(
    .NUM_CH      (NUM_CH),
    .DIV_W       (DIV_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DIV_RST     (DIV_RST)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_locked     (locked),
    .i_div        (div),
    .i_div_load   (div_load),
    .i_ch_en      (ch_en),
    .i_clr_status (clr),
    .o_ce         (ce),
    .o_ready      (ready),
    .o_rst_out    (rst_out),
    .o_lost_lock  (lost)
  );

  always @(negedge clk) begin
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      total++;
      if ((ce & e.mask) !== (e.ce & e.mask)) begin
        bad++;
        $display("FAIL sb_ce got=%b want=%b mask=%b t=%0t", ce, e.ce, e.mask, $time);
      end
    end
  end

  task automatic push_periodic(input int n, input int d[NUM_CH], input logic [NUM_CH-1:0] en);
    sb_t e;
    for (int k = 1; k <= n; k++) begin
      e.mask = '1;
      for (int c = 0; c < NUM_CH; c++) begin
        int p;
        p = (d[c] == 0) ? 1 : d[c];
        e.ce[c] = en[c] && ((k % p) == 0);
      end
      sb_q.push_back(e);
    end
  endtask

  task automatic drain();
    int g = 0;
    while (sb_q.size() > 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    #1;
    total++;
    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL sb_timeout left=%0d want=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!ready && n < 100);
  endtask

  task automatic do_reset();
    rst = 1'b1; locked = 1'b0; div_load = 1'b0; clr = 1'b0;
    ch_en = '0; div = {NUM_CH{8'd1}};
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; locked = 1'b0; div_load = 1'b0; clr = 1'b0;
    ch_en = '1; div = {NUM_CH{8'd1}};
    repeat (3) @(negedge clk);
    total++; if (ce !== '0)       begin bad++; $display("FAIL rst_ce got=%b want=0000", ce); end
    total++; if (ready !== 1'b0)  begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
    total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL rst_rst_out got=%b want=1", rst_out); end
    total++; if (lost !== 1'b0)   begin bad++; $display("FAIL rst_lost got=%b want=0", lost); end
  endtask

  task automatic test_power_up();
    int n;
    int d[NUM_CH] = '{1, 1, 1, 1};
    do_reset();
    ch_en  = 4'b1011;
    locked = 1'b1;
    wait_ready(n);
    total++; if (n !== EXP_EDGES) begin bad++; $display("FAIL pu_edges got=%0d want=%0d", n, EXP_EDGES); end
    total++; if (rst_out !== 1'b0) begin bad++; $display("FAIL pu_rst_out got=%b want=0", rst_out); end
    total++; if (ce !== '0) begin bad++; $display("FAIL pu_ce0 got=%b want=0000", ce); end
    #1;
    push_periodic(12, d, ch_en);
    drain();
  endtask

  task automatic test_lock_glitch();
    int n;
    int seen = 0;
    do_reset();
    ch_en  = '1;
    locked = 1'b1;
    repeat (5) @(negedge clk);
    locked = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ready) seen = 1;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL glitch_ready got=1 want=0"); end
    locked = 1'b1;
    wait_ready(n);
    total++; if (n !== EXP_EDGES) begin bad++; $display("FAIL glitch_edges got=%0d want=%0d", n, EXP_EDGES); end
  endtask

  task automatic test_divisors();
    int n;
    int d[NUM_CH] = '{2, 3, 7, 0};
    do_reset();
    div      = {8'd0, 8'd7, 8'd3, 8'd2};
    ch_en    = '1;
    div_load = 1'b1;
    @(negedge clk);
    div_load = 1'b0;
    locked   = 1'b1;
    wait_ready(n);
    total++; if (n !== EXP_EDGES) begin bad++; $display("FAIL div_edges got=%0d want=%0d", n, EXP_EDGES); end
    total++; if (ce !== '0) begin bad++; $display("FAIL div_ce0 got=%b want=0000", ce); end
    #1;
    push_periodic(30, d, ch_en);
    drain();
  endtask

  task automatic test_retune();
    int g = 0;
    sb_t e;
    while (!ce[1] && g < 20) begin
      @(negedge clk);
      g++;
    end
    total++; if (ce[1] !== 1'b1) begin bad++; $display("FAIL retune_find got=%b want=1", ce[1]); end
    div      = {8'd0, 8'd7, 8'd5, 8'd2};
    div_load = 1'b1;
    #1;
    for (int k = 1; k <= 20; k++) begin
      e.mask = 4'b0010;
      e.ce   = (k == 3 || (k > 3 && ((k - 3) % 5) == 0)) ? 4'b0010 : 4'b0000;
      sb_q.push_back(e);
    end
    @(negedge clk);
    div_load = 1'b0;
    drain();
  endtask

  task automatic test_lock_loss();
    int d[NUM_CH] = '{1, 1, 1, 1};
    total++; if (lost !== 1'b0) begin bad++; $display("FAIL loss_pre got=%b want=0", lost); end
    locked = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL loss_ready_e1 got=%b want=1", ready); end
    clr = 1'b1;
    @(posedge clk); @(negedge clk);
    clr = 1'b0;
    total++; if (ready !== 1'b0)   begin bad++; $display("FAIL loss_ready got=%b want=0", ready); end
    total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL loss_rst_out got=%b want=1", rst_out); end
    total++; if (lost !== 1'b1)    begin bad++; $display("FAIL loss_flag got=%b want=1", lost); end
    total++; if (ce !== '0)        begin bad++; $display("FAIL loss_ce got=%b want=0000", ce); end
    #1;
    push_periodic(8, d, 4'b0000);
    drain();
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL loss_ready_hold got=%b want=0", ready); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    total++; if (lost !== 1'b0) begin bad++; $display("FAIL loss_clear got=%b want=0", lost); end
  endtask

  task automatic test_reset_mid_run();
    int n;
    int d[NUM_CH] = '{1, 1, 1, 1};
    locked = 1'b1;
    wait_ready(n);
    total++; if (n !== EXP_EDGES) begin bad++; $display("FAIL mid_edges1 got=%0d want=%0d", n, EXP_EDGES); end
    locked = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (lost !== 1'b1) begin bad++; $display("FAIL mid_lost got=%b want=1", lost); end
    locked = 1'b1;
    wait_ready(n);
    total++; if (n !== EXP_EDGES) begin bad++; $display("FAIL mid_edges2 got=%0d want=%0d", n, EXP_EDGES); end
    repeat (7) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (ready !== 1'b0)   begin bad++; $display("FAIL mid_ready got=%b want=0", ready); end
    total++; if (rst_out !== 1'b1) begin bad++; $display("FAIL mid_rst_out got=%b want=1", rst_out); end
    total++; if (lost !== 1'b0)    begin bad++; $display("FAIL mid_lost_clr got=%b want=0", lost); end
    total++; if (ce !== '0)        begin bad++; $display("FAIL mid_ce got=%b want=0000", ce); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    total++; if (n !== EXP_EDGES) begin bad++; $display("FAIL mid_edges3 got=%0d want=%0d", n, EXP_EDGES); end
    #1;
    push_periodic(10, d, ch_en);
    drain();
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_divisors();
    test_retune();
    test_lock_loss();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
